contador_bcd: RTL and testbench

Programmable 4-bit up/down counter with built-in prescaler that drives the display decoder directly. The code count value is presented on A (MSB) through D (LSB) and wired straight to the 7-segment decoder inputs of the same names. A one-cycle terminal-count pulse is provided so digits can be cascaded. Sits between the board clock/switches and the display decoder.

---
 rtl/contador_bcd_pkg.sv | 12 +
 rtl/contador_bcd_if.sv | 25 ++
 rtl/contador_bcd_divisor_tick.sv | 31 +++
 rtl/contador_bcd.sv | 56 +++++
 tb/tb_contador_bcd.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/contador_bcd_pkg.sv
// rtl/contador_bcd_pkg.sv - shared constants and prescaler width helper for the BCD digit counter
package display_pkg;

    localparam int CODE_W      = 4;
    localparam int DEFAULT_MAX = 9;

    // Prescaler needs to hold 0..DIV-1; keep at least one bit so DIV=1 still elaborates.
    function automatic int pre_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/contador_bcd_if.sv
// rtl/contador_bcd_if.sv - control inputs and decoder-facing outputs of one counter digit
interface contador_bcd_if;
    import display_pkg::*;

    logic              en;
    logic              up;
    logic              load;
    logic [CODE_W-1:0] load_val;
    logic              A;
    logic              B;
    logic              C;
    logic              D;
    logic              tc;

    modport master (
        output en, up, load, load_val,
        input  A, B, C, D, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output A, B, C, D, tc
    );

endinterface

// File: rtl/contador_bcd_divisor_tick.sv
// rtl/contador_bcd_divisor_tick.sv - prescaler producing a count-step tick every DIV enabled cycles
module divisor_tick
    import display_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = pre_width(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;

    assign tick = en & (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clr || tick) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre + 1'b1;
        end
    end

endmodule

// File: rtl/contador_bcd.sv
// rtl/contador_bcd.sv - programmable up/down digit counter with prescaler and cascade pulse
module contador_bcd
    import display_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000,
    parameter int unsigned MAX = DEFAULT_MAX
) (
    input  logic           clk,
    input  logic           rst_n,
    contador_bcd_if.slave  bus
);

    localparam logic [CODE_W-1:0] MAX_V = CODE_W'(MAX);

    logic              tick;
    logic [CODE_W-1:0] count;
    logic              tc_q;

    divisor_tick #(
        .DIV (DIV)
    ) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.load),
        .tick  (tick)
    );

    // Load outranks tick so a coincident load never also steps or pulses tc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            tc_q  <= 1'b0;
        end else if (bus.load) begin
            count <= (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
            tc_q  <= 1'b0;
        end else if (tick) begin
            if (bus.up) begin
                count <= (count == MAX_V) ? '0 : count + 1'b1;
                tc_q  <= (count == MAX_V);
            end else begin
                count <= (count == '0) ? MAX_V : count - 1'b1;
                tc_q  <= (count == '0);
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.A  = count[3];
    assign bus.B  = count[2];
    assign bus.C  = count[1];
    assign bus.D  = count[0];
    assign bus.tc = tc_q;

endmodule

// File: tb/tb_contador_bcd.sv
// tb/tb_contador_bcd.sv - scoreboard bench for contador_bcd at DIV=4/MAX=9 and DIV=1/MAX=1
module tb_contador_bcd;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    contador_bcd_if bus4 ();
    contador_bcd_if bus1 ();

    contador_bcd #(.DIV(4), .MAX(9)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    contador_bcd #(.DIV(1), .MAX(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [4:0] e4;
        logic [4:0] e1;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int m_div[2] = '{4, 1};
    int m_max[2] = '{9, 1};
    int m_pre[2];
    int m_cnt[2];
    int m_tc[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written from the counter's description.
    task automatic model_step(input int k, input logic r, input logic e, input logic u,
                              input logic l, input int lv);
        if (!r) begin
            m_pre[k] = 0; m_cnt[k] = 0; m_tc[k] = 0;
        end else if (l) begin
            m_cnt[k] = (lv > m_max[k]) ? m_max[k] : lv;
            m_pre[k] = 0; m_tc[k] = 0;
        end else if (e && m_pre[k] == m_div[k] - 1) begin
            m_pre[k] = 0;
            if (u) begin
                m_tc[k]  = (m_cnt[k] == m_max[k]) ? 1 : 0;
                m_cnt[k] = (m_cnt[k] == m_max[k]) ? 0 : m_cnt[k] + 1;
            end else begin
                m_tc[k]  = (m_cnt[k] == 0) ? 1 : 0;
                m_cnt[k] = (m_cnt[k] == 0) ? m_max[k] : m_cnt[k] - 1;
            end
        end else begin
            if (e) m_pre[k] = m_pre[k] + 1;
            m_tc[k] = 0;
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic u, input logic l, input int lv);
        exp_t x;
        @(posedge clk);
        #2;
        rst_n = r;
        bus4.en = e; bus4.up = u; bus4.load = l; bus4.load_val = 4'(lv);
        bus1.en = e; bus1.up = u; bus1.load = l; bus1.load_val = 4'(lv);
        model_step(0, r, e, u, l, lv);
        model_step(1, r, e, u, l, lv);
        x.e4 = {4'(m_cnt[0]), m_tc[0][0]};
        x.e1 = {4'(m_cnt[1]), m_tc[1][0]};
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sb_div4", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, x.e4);
            chk("sb_div1", {bus1.A, bus1.B, bus1.C, bus1.D, bus1.tc}, x.e1);
        end
    end

    initial begin
        rst_n = 1'b0;
        bus4.en = 1'b0; bus4.up = 1'b1; bus4.load = 1'b0; bus4.load_val = '0;
        bus1.en = 1'b0; bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = '0;

        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0);
        chk("first_step", {bus4.A, bus4.B, bus4.C, bus4.D}, 4'd1);
        for (int i = 0; i < 36; i++) cyc(1, 1, 1, 0, 0);
        chk("wrap_up", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, 5'b0000_1);

        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0);
        chk("wrap_down", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, 5'b1001_1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        chk("down_next", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, 5'b1000_0);

        cyc(1, 1, 1, 1, 12);
        cyc(1, 0, 1, 0, 0);
        chk("load_clamp", {bus4.A, bus4.B, bus4.C, bus4.D}, 4'd9);

        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 5);
        cyc(1, 1, 1, 0, 0);
        chk("load_vs_tick", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, 5'b0101_0);

        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("gap_hold", {bus4.A, bus4.B, bus4.C, bus4.D}, 4'd5);
        cyc(1, 1, 1, 0, 0);
        chk("gap_step", {bus4.A, bus4.B, bus4.C, bus4.D}, 4'd6);

        cyc(1, 1, 1, 1, 9);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rst_at_wrap", {bus4.A, bus4.B, bus4.C, bus4.D, bus4.tc}, 5'b0000_0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0);
        chk("resume", {bus4.A, bus4.B, bus4.C, bus4.D}, 4'd1);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #3;
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
